// File: rtl/register_with_freeze_and_flush_pkg.sv
// register_with_freeze_and_flush_pkg: shared pipeline stage widths and bubble encoding
package register_with_freeze_and_flush_pkg;

   // ID stage register fields, concatenated MSB-first by the stage wrapper
   localparam int ID_PC_W    = 32;
   localparam int ID_INSTR_W = 32;
   localparam int ID_RS1D_W  = 32;
   localparam int ID_RS2D_W  = 32;
   localparam int ID_IMM_W   = 32;
   localparam int ID_RD_W    = 5;
   localparam int ID_RS1_W   = 5;
   localparam int ID_RS2_W   = 5;
   localparam int ID_CTRL_W  = 14;

   localparam int ID_STAGE_W = ID_PC_W + ID_INSTR_W + ID_RS1D_W + ID_RS2D_W + ID_IMM_W
                             + ID_RD_W + ID_RS1_W + ID_RS2_W + ID_CTRL_W;

   // A bubble is all zeros: no writeback, no memory access
   localparam logic BUBBLE_BIT = 1'b0;

endpackage

// File: rtl/register_with_freeze_and_flush.sv
// register_with_freeze_and_flush: pipeline stage register with stall (freeze) and bubble insertion (flush)
module register_with_freeze_and_flush
   import register_with_freeze_and_flush_pkg::*;
#(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter logic [WIDTH-1:0] FLUSH_VALUE = {WIDTH{BUBBLE_BIT}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             freeze,
   input  logic             flush,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out
);

   if (WIDTH < 1) begin : g_width_check
      $error("register_with_freeze_and_flush: WIDTH must be >= 1");
   end

   logic [WIDTH-1:0] out_d, out_q;

   // Flush beats freeze so a stalled stage can still be turned into a bubble
   always_comb out_d = flush ? FLUSH_VALUE : freeze ? out_q : in;

   // Storage flops; reset is asynchronous and overrides everything
   always_ff @(posedge clk or posedge rst)
      if (rst) out_q <= RESET_VALUE;
      else     out_q <= out_d;

   assign out = out_q;

endmodule

// File: tb/tb_register_with_freeze_and_flush.sv
// tb_register_with_freeze_and_flush: directed plus randomized check against a behavioural model
module tb_register_with_freeze_and_flush;
   import register_with_freeze_and_flush_pkg::*;

   localparam int WW = 189;
   localparam logic [31:0] RV_B = 32'hCAFEF00D;
   localparam logic [31:0] FV_B = 32'h0000FFFF;

   logic clk = 1'b0;
   logic rst, freeze, flush;
   logic [31:0] in32, out_a, out_b;
   logic [WW-1:0] in_w, out_w;
   logic [31:0] exp_a, exp_b;
   logic [WW-1:0] exp_w;
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   register_with_freeze_and_flush dut_a (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .in(in32), .out(out_a));

   register_with_freeze_and_flush #(.WIDTH(32), .RESET_VALUE(RV_B), .FLUSH_VALUE(FV_B)) dut_b (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .in(in32), .out(out_b));

   register_with_freeze_and_flush #(ID_STAGE_W) dut_w (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .in(in_w), .out(out_w));

   task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "/a"}, WW'(out_a), WW'(exp_a));
      check({tag, "/b"}, WW'(out_b), WW'(exp_b));
      check({tag, "/w"}, out_w, exp_w);
   endtask

   // Change reset away from any clock edge; assertion takes effect immediately
   task automatic set_rst(input logic v, input string tag);
      rst = v;
      if (v) begin
         exp_a = '0;
         exp_b = RV_B;
         exp_w = '0;
      end
      #1 check_all(tag);
   endtask

   // Called just after a falling edge; applies one rising edge
   task automatic step(input logic f, input logic z, input logic [31:0] d,
                       input logic [WW-1:0] dw, input string tag);
      flush  = f;
      freeze = z;
      in32   = d;
      in_w   = dw;
      #1 check_all({tag, "/pre"});
      @(posedge clk);
      if (!rst) begin
         if (f) begin
            exp_a = '0;
            exp_b = FV_B;
            exp_w = '0;
         end else if (!z) begin
            exp_a = d;
            exp_b = d;
            exp_w = dw;
         end
      end
      #1 check_all(tag);
      flush  = 1'($urandom);
      freeze = 1'($urandom);
      #1 flush = f;
      @(negedge clk);
   endtask

   function automatic logic [WW-1:0] rand_w();
      logic [191:0] r;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      return r[WW-1:0];
   endfunction

   logic [WW-1:0] alt, one;

   initial begin
      rst = 1'b1; flush = 1'b1; freeze = 1'b1; in32 = '1; in_w = '1;
      exp_a = '0; exp_b = RV_B; exp_w = '0;
      #1 check_all("reset");
      @(negedge clk);
      step(1'b1, 1'b1, 32'hFFFFFFFF, '1, "reset_hold");
      set_rst(1'b0, "reset_release");
      step(1'b0, 1'b0, 32'hDEADBEEF, rand_w(), "load_deadbeef");
      #1 set_rst(1'b1, "async_reset");
      step(1'b0, 1'b0, 32'hFFFFFFFF, '1, "reset_over_in");
      step(1'b1, 1'b1, 32'hFFFFFFFF, '1, "reset_over_ctrl");
      set_rst(1'b0, "reset_release2");
      step(1'b0, 1'b0, 32'h12345678, rand_w(), "load_12345678");
      step(1'b0, 1'b0, 32'h0000000A, rand_w(), "load_0000000a");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h55555555, rand_w(), "freeze");
      step(1'b0, 1'b0, 32'h55555555, rand_w(), "unfreeze");
      step(1'b1, 1'b0, 32'hAAAAAAAA, rand_w(), "flush");
      step(1'b0, 1'b0, 32'hAAAAAAAA, rand_w(), "after_flush");
      step(1'b0, 1'b0, 32'h13579BDF, rand_w(), "load_13579bdf");
      step(1'b1, 1'b1, 32'h2468ACE0, rand_w(), "flush_and_freeze");
      for (int i = 0; i < WW; i++) alt[i] = (i % 2 == 0);
      step(1'b0, 1'b0, 32'h1, alt, "wide_alt");
      step(1'b0, 1'b0, 32'h2, ~alt, "wide_alt_inv");
      one = '0; one[WW-1] = 1'b1;
      step(1'b0, 1'b0, 32'h80000000, one, "wide_msb");
      one = '0; one[0] = 1'b1;
      step(1'b0, 1'b0, 32'h00000001, one, "wide_lsb");
      step(1'b0, 1'b0, 32'h3, '1, "wide_ones");
      step(1'b0, 1'b1, 32'h4, alt, "wide_freeze");
      set_rst(1'b1, "reset_mid_freeze");
      step(1'b0, 1'b1, 32'h5, alt, "reset_mid_freeze_hold");
      set_rst(1'b0, "reset_release3");
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 24) == 0) set_rst(1'b1, "rand_rst");
         else if (rst) set_rst(1'b0, "rand_rst_release");
         step($urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, $urandom, rand_w(), "random");
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
